// File: rtl/spi_regs_pkg.sv
// spi_regs_pkg: shared constants and types for the SPI register-bank target.
//   Address map, frame length, status bit positions and the FSM state encoding.
package spi_regs_pkg;
    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;
    localparam logic [6:0] ADDR_STATUS    = 7'h05;

    localparam int FRAME_BITS = 16;

    localparam int ST_SHORT = 0;
    localparam int ST_LONG  = 1;
    localparam int ST_BAD   = 2;

    typedef enum logic [1:0] {ARM, IDLE, ACTIVE} state_t;
endpackage

// File: rtl/edge_detect.sv
// edge_detect: one-register edge detector for an already-synchronized signal.
//   clk, rst : system clock, asynchronous active-high reset
//   d        : synchronized input
//   rise     : d=1 while the previous sample was 0
//   fall     : d=0 while the previous sample was 1
//   RST_VAL  : value the previous-sample register takes during reset
module edge_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic prev;

    always_ff @(posedge clk or posedge rst)
        if (rst) prev <= RST_VAL;
        else     prev <= d;

    assign rise = d & ~prev;
    assign fall = ~d & prev;
endmodule

// File: rtl/spi_regfile_rw.sv
// spi_regfile_rw: mode-0 SPI target holding the PWM configuration registers.
//   clk, rst          : system clock, asynchronous active-high reset
//   sclk_s/copi_s/ncs_s : synchronized SPI inputs (nCS active low)
//   cipo, cipo_oe     : read-back data and its drive enable
//   en_reg_* / pwm_duty_cycle : registers at addresses 0x00..0x04
//   wr_strobe, wr_addr : one-cycle pulse and address of each committed write
//   Frame: bit15 R/W (1=write), bits14:8 address, bits7:0 data, MSB first.
module spi_regfile_rw
    import spi_regs_pkg::*;
#(
    parameter logic [6:0] MAX_ADDR   = 7'h05,
    parameter int         FRAME_BITS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_s,
    input  logic       copi_s,
    input  logic       ncs_s,
    output logic       cipo,
    output logic       cipo_oe,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic [6:0] wr_addr
);
    localparam logic [4:0] FULL = 5'(FRAME_BITS);
    localparam logic [4:0] SAT  = 5'(FRAME_BITS + 1);

    state_t      state;
    logic [15:0] shift;
    logic [4:0]  cnt;
    logic [7:0]  shadow;
    logic [2:0]  status;
    logic [7:0]  rd_data;
    logic        sclk_rise, sclk_fall, ncs_rise, ncs_fall;

    wire  [6:0]  addr = shift[14:8];
    wire  [7:0]  data = shift[7:0];

    edge_detect #(.RST_VAL(1'b1)) u_sclk (
        .clk(clk), .rst(rst), .d(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    edge_detect #(.RST_VAL(1'b1)) u_ncs (
        .clk(clk), .rst(rst), .d(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
    );

    // After 8 bits the address sits in shift[6:0] and R/W in shift[7].
    always_comb begin
        rd_data = 8'h00;
        case (shift[6:0])
            ADDR_EN_OUT_LO: rd_data = en_reg_out_7_0;
            ADDR_EN_OUT_HI: rd_data = en_reg_out_15_8;
            ADDR_EN_PWM_LO: rd_data = en_reg_pwm_7_0;
            ADDR_EN_PWM_HI: rd_data = en_reg_pwm_15_8;
            ADDR_DUTY:      rd_data = pwm_duty_cycle;
            ADDR_STATUS:    rd_data = {5'b0, status};
            default:        rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ARM;
            shift           <= '0;
            cnt             <= '0;
            shadow          <= '0;
            cipo_oe         <= 1'b0;
            status          <= '0;
            wr_strobe       <= 1'b0;
            wr_addr         <= '0;
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
        end else begin
            wr_strobe <= 1'b0;
            case (state)
                // Never join a transfer that was already running at reset release.
                ARM: if (ncs_s) state <= IDLE;
                IDLE: if (ncs_fall) begin
                    shift <= '0;
                    cnt   <= '0;
                    state <= ACTIVE;
                end
                ACTIVE: begin
                    if (ncs_rise) begin
                        state   <= IDLE;
                        cipo_oe <= 1'b0;
                        shadow  <= '0;
                        if (cnt == FULL && shift[15]) begin
                            if (addr > MAX_ADDR) begin
                                status[ST_BAD] <= 1'b1;
                            end else begin
                                wr_strobe <= 1'b1;
                                wr_addr   <= addr;
                                case (addr)
                                    ADDR_EN_OUT_LO: en_reg_out_7_0  <= data;
                                    ADDR_EN_OUT_HI: en_reg_out_15_8 <= data;
                                    ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= data;
                                    ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= data;
                                    ADDR_DUTY:      pwm_duty_cycle  <= data;
                                    default:        status          <= status & ~data[2:0];
                                endcase
                            end
                        end else if (cnt == SAT) begin
                            status[ST_LONG] <= 1'b1;
                        end else if (cnt != 5'd0 && cnt != FULL) begin
                            status[ST_SHORT] <= 1'b1;
                        end
                    end else begin
                        if (sclk_rise) begin
                            shift <= {shift[14:0], copi_s};
                            cnt   <= (cnt == SAT) ? cnt : cnt + 5'd1;
                        end
                        if (sclk_fall) begin
                            if (cnt == 5'd8 && !shift[7]) begin
                                shadow  <= rd_data;
                                cipo_oe <= 1'b1;
                            end else if (cipo_oe) begin
                                shadow <= {shadow[6:0], 1'b0};
                            end
                        end
                    end
                end
                default: state <= ARM;
            endcase
        end
    end

    assign cipo = cipo_oe & shadow[7];
endmodule

// File: tb/tb_spi_regfile_rw.sv
// tb_spi_regfile_rw: directed self-checking bench for spi_regfile_rw.
module tb_spi_regfile_rw;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic       cipo, cipo_oe, wr_strobe;
    logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;
    logic [6:0] wr_addr;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         strobes = 0;
    int         bidx, oe_cnt;
    logic [7:0] cap, rd;
    int         s0;

    localparam int H = 6;

    spi_regfile_rw dut (
        .clk(clk), .rst(rst), .sclk_s(sclk), .copi_s(copi), .ncs_s(ncs),
        .cipo(cipo), .cipo_oe(cipo_oe),
        .en_reg_out_7_0(out_lo), .en_reg_out_15_8(out_hi),
        .en_reg_pwm_7_0(pwm_lo), .en_reg_pwm_15_8(pwm_hi),
        .pwm_duty_cycle(duty), .wr_strobe(wr_strobe), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_strobe) strobes++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sbit(input logic b);
        copi = b;
        tick(H);
        if (bidx >= 8 && bidx < 16) cap = {cap[6:0], cipo};
        if (cipo_oe) oe_cnt++;
        sclk = 1'b1;
        tick(H);
        sclk = 1'b0;
        bidx++;
    endtask

    task automatic begin_frame;
        ncs = 1'b0;
        bidx = 0;
        oe_cnt = 0;
        cap = 8'h00;
        tick(H);
    endtask

    task automatic end_frame;
        tick(H);
        ncs = 1'b1;
    endtask

    task automatic xfer(input logic [31:0] w, input int n);
        begin_frame;
        for (int i = n - 1; i >= 0; i--) sbit(w[i]);
        end_frame;
    endtask

    task automatic spi_wr(input logic [15:0] w);
        xfer({16'h0, w}, 16);
        tick(H);
    endtask

    task automatic spi_rd(input logic [6:0] a, output logic [7:0] d);
        xfer({16'h0, 1'b0, a, 8'h00}, 16);
        tick(H);
        d = cap;
    endtask

    initial begin
        tick(3);
        check("rst_cipo", cipo, 0);
        check("rst_oe", cipo_oe, 0);
        check("rst_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_regs", {out_lo, out_hi, pwm_lo, pwm_hi}, 0);
        check("rst_duty", duty, 0);
        rst = 1'b0;
        tick(4);

        // duty write: value and strobe one cycle after nCS rise
        xfer(32'h8480, 16);
        check("duty_before", duty, 8'h00);
        tick(1);
        check("duty_after", duty, 8'h80);
        check("strobe_hi", wr_strobe, 1);
        tick(1);
        check("strobe_lo", wr_strobe, 0);
        check("strobe_cnt", strobes, 1);
        check("wr_addr_4", wr_addr, 7'h04);
        tick(H);

        // write then read back on CIPO
        spi_wr(16'h81A5);
        check("out_hi", out_hi, 8'hA5);
        s0 = strobes;
        spi_rd(7'h01, rd);
        check("rd_01", rd, 8'hA5);
        check("rd_oe_window", oe_cnt, 8);
        check("rd_oe_after", cipo_oe, 0);
        check("rd_cipo_after", cipo, 0);
        check("rd_no_strobe", strobes, s0);
        check("rd_regs_same", {out_hi, duty}, 16'hA580);
        spi_rd(7'h04, rd);
        check("rd_04", rd, 8'h80);
        spi_rd(7'h30, rd);
        check("rd_unmapped", rd, 8'h00);

        // short, long, then W1C
        s0 = strobes;
        xfer(32'h8F3, 12);
        tick(H);
        check("short_regs", {out_lo, out_hi, pwm_lo, pwm_hi, duty}, 40'h00A5000080);
        spi_rd(7'h05, rd);
        check("status_short", rd, 8'h01);
        xfer(32'h84FFF, 20);
        tick(H);
        check("long_duty", duty, 8'h80);
        spi_rd(7'h05, rd);
        check("status_long", rd, 8'h03);
        check("bad_frames_no_strobe", strobes, s0);
        spi_wr(16'h8503);
        check("w1c_strobe", strobes, s0 + 1);
        spi_rd(7'h05, rd);
        check("status_clr", rd, 8'h00);

        // out-of-range write
        spi_wr(16'h8377);
        check("pwm_hi", pwm_hi, 8'h77);
        check("wr_addr_3", wr_addr, 7'h03);
        s0 = strobes;
        spi_wr(16'h9055);
        check("bad_no_strobe", strobes, s0);
        check("bad_wr_addr", wr_addr, 7'h03);
        check("bad_regs", {out_lo, out_hi, pwm_lo, pwm_hi, duty}, 40'h00A5007780);
        spi_rd(7'h05, rd);
        check("status_bad", rd, 8'h04);
        spi_wr(16'h8504);
        spi_rd(7'h05, rd);
        check("status_bad_clr", rd, 8'h00);

        // reset in the middle of a write frame
        begin_frame;
        for (int i = 15; i >= 7; i--) sbit(1'(16'h82C3 >> i));
        rst = 1'b1;
        #1;
        check("async_rst_regs", {out_hi, pwm_hi, duty}, 0);
        check("async_rst_oe", cipo_oe, 0);
        tick(2);
        rst = 1'b0;
        s0 = strobes;
        for (int i = 6; i >= 0; i--) sbit(1'(16'h82C3 >> i));
        end_frame;
        tick(H);
        check("midrst_pwm_lo", pwm_lo, 8'h00);
        check("midrst_no_strobe", strobes, s0);
        spi_rd(7'h05, rd);
        check("midrst_status", rd, 8'h00);
        spi_wr(16'h82C3);
        check("post_rst_write", pwm_lo, 8'hC3);

        // SCLK activity with nCS high is ignored
        s0 = strobes;
        repeat (20) begin
            copi = ~copi;
            tick(H);
            sclk = 1'b1;
            tick(H);
            sclk = 1'b0;
        end
        check("idle_sclk_duty", duty, 8'h00);
        check("idle_sclk_no_strobe", strobes, s0);
        spi_wr(16'h8412);
        check("idle_then_write", duty, 8'h12);
        check("idle_then_strobe", strobes, s0 + 1);
        spi_rd(7'h05, rd);
        check("idle_status", rd, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_regfile_rw.md
# spi_regfile_rw

Register-bank SPI target that sits between the `input_sync` stage and the PWM peripheral. It receives already-synchronized SPI signals (mode 0, 16-bit frames) and holds the five PWM configuration registers that drive the PWM block. It also supports register read-back on CIPO and keeps a sticky frame-error status register. It replaces the write-only register path and is the sole owner of the PWM configuration state.

## Interface
Parameters:
- `MAX_ADDR`, default 7'h05: highest valid address; reaching `status` requires 5.
- `FRAME_BITS`, default 16: bits per valid frame; fixed at 16, not for override.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `sclk_s` in 1: synchronized SCLK.
- `copi_s` in 1: synchronized COPI.
- `ncs_s` in 1: synchronized nCS, active low.
- `cipo` out 1: read data; 0 whenever `cipo_oe` is 0.
- `cipo_oe` out 1: CIPO drive enable.
- `en_reg_out_7_0` out 8: address 0x00.
- `en_reg_out_15_8` out 8: address 0x01.
- `en_reg_pwm_7_0` out 8: address 0x02.
- `en_reg_pwm_15_8` out 8: address 0x03.
- `pwm_duty_cycle` out 8: address 0x04.
- `wr_strobe` out 1: one-cycle pulse on every committed write.
- `wr_addr` out 7: address of the last committed write; holds its value between writes.

## Operation
- Frame format, MSB first: bit15 R/W (1 = write), bits14:8 address, bits7:0 data.
- COPI is sampled on SCLK rise. CIPO changes on SCLK fall.
- Status register, address 0x05:
  - bit0 `short_frame`: nCS rose with 1–15 bits received.
  - bit1 `long_frame`: more than 16 bits received.
  - bit2 `bad_addr`: write to an address greater than `MAX_ADDR`.
  - bits7:3 read as 0.
  - All bits sticky; writing 1 to a bit clears it.
- Edge detection: `sclk_prev` and `ncs_prev` registers.
  - A rise is cur=1, prev=0; a fall is the reverse.
  - Both prev registers reset to 1.
- FSM states:
  - ARM (reset state): wait for `ncs_s`=1, then go to IDLE. No frame can start from a transfer already in progress at reset release.
  - IDLE: an nCS fall clears the shift register and the 5-bit bit counter, then go to ACTIVE.
  - ACTIVE:
    - Each SCLK rise shifts in COPI and increments the counter. The counter saturates at 17.
    - SCLK fall with count==8 and R/W=0: load the read shadow from the addressed register and set `cipo_oe`=1. `cipo` = shadow[7].
    - Each later SCLK fall shifts the shadow left.
    - nCS rise: evaluate the frame, go to IDLE, and clear `cipo_oe`.
- Frame evaluation at nCS rise:
  - count==16, write, address ≤ 4: update the register, pulse `wr_strobe`, load `wr_addr`.
  - count==16, write, address 5: write-1-clear on status, pulse `wr_strobe`.
  - count==16, write, address > 5: no register change, set `bad_addr`, no strobe.
  - count 1–15: set `short_frame`, no update.
  - count 17: set `long_frame`, no update.
  - count 0: no effect.
  - A read frame never changes registers or status.
- Read of an address > 5 returns 0x00.
- SCLK edges while in IDLE or ARM are ignored.
- A status set event and a W1C on the same bit in the same frame cannot occur, because the write path requires count==16.

## Timing
- Reset values: all registers 0x00; `status` 0; `cipo`, `cipo_oe`, `wr_strobe` 0; `wr_addr` 0; state ARM.
- Write latency: nCS rise appears on `ncs_s` in cycle N, is detected in N, and the register value plus `wr_strobe` are visible in cycle N+1. `wr_strobe` is high for exactly one cycle.
- CIPO is valid from the cycle after the 8th SCLK fall is detected. The external SCLK half-period must be at least 4 `clk` cycles, which covers the 2-flop synchronizer, edge detection and CIPO update.
- Reset asserted mid-frame: all state returns to reset values immediately and asynchronously. After release, the block sits in ARM until nCS is seen high.

## Structure
- Shared package `spi_regs_pkg`:
  - Address constants `ADDR_EN_OUT_LO`=0, `ADDR_EN_OUT_HI`=1, `ADDR_EN_PWM_LO`=2, `ADDR_EN_PWM_HI`=3, `ADDR_DUTY`=4, `ADDR_STATUS`=5.
  - `FRAME_BITS`=16.
  - Status bit indices.
  - FSM state encoding: ARM, IDLE, ACTIVE.
- Sub-module `edge_detect`: prev register plus rise/fall outputs, reset value as a parameter. Instantiated twice, for SCLK and nCS.

## Test plan
- Write 0x8000|0x04<<8|0x80: `pwm_duty_cycle`=0x80 one cycle after nCS rise; `wr_strobe` is a single pulse; `wr_addr`=0x04.
- Write 0x01=0xA5, then read frame 0x0100: CIPO shifts out 1,0,1,0,0,1,0,1 on bits 8–15; `cipo_oe` is high only in that window; registers are unchanged.
- Frame of 12 bits: no register changes; status=0x01. Then a 20-bit frame: status=0x03. Then write 0x05=0x03: status=0x00.
- Write to address 0x10: all registers unchanged, no strobe, status bit2=1.
- Assert `rst` at bit 9 of a write to 0x02, release while nCS is still low, finish the frame: 0x02 stays 0x00, status stays 0. The next full frame is accepted.
- SCLK toggling with nCS high for 40 edges, then a valid write: only the valid write takes effect.
